ifetch_unit: RTL and testbench
==============================

Name: ifetch_unit

Overview:
Instruction fetch front end. It produces the opcode/instruction stream that the decode stage's controlunit consumes; the controlunit is the decode side, and this block is the supply side of that opcode interface. It holds the PC, issues word requests to instruction memory over a valid/ready channel and buffers returned words in a small FIFO. It presents {inst, pc, opcode} to decode with valid/ready and handles branch redirects, including discarding stale in-flight responses.

Parameters:
ADDR_W, 32, PC/address width in bits
RESET_PC, 32'h0000_0000, PC loaded on reset
FIFO_DEPTH, 2, instruction buffer entries (power of 2, >=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  ADDR_W  word-aligned fetch address
imem_rsp_valid  in  1  response word valid (in order, one per accepted request, latency >=1 cycle)
imem_rsp_data  in  32  response instruction word
inst_valid  out  1  instruction available to decode
inst_ready  in  1  decode consumes instruction
inst_data  out  32  instruction word
inst_pc  out  ADDR_W  PC of inst_data
opcode  out  7  inst_data[6:0], feeds controlunit opcode input
redirect_valid  in  1  branch/jump taken, one-cycle pulse
redirect_pc  in  ADDR_W  new fetch target

Behaviour:
- Reset (async assert, sync release): fetch_pc=RESET_PC, FIFO empty, outstanding=0, discard=0, state=IDLE. Outputs: imem_req_valid=0, imem_req_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0, opcode=0.
- Only one request may be outstanding at a time.
- FSM:
  - IDLE: if FIFO has a free slot, not counting the reserved in-flight slot, go to REQ.
  - REQ: drive imem_req_valid=1, imem_req_addr=fetch_pc.
    - On imem_req_ready: fetch_pc+=4, go to WAIT.
    - Address and valid stay stable until accepted.
  - WAIT: on imem_rsp_valid, push {data, pc} into the FIFO unless discard=1. Then go to REQ if a slot is free, else IDLE.
- Slot reservation: a request is issued only if (FIFO count + outstanding) < FIFO_DEPTH, so the FIFO never overflows.
- Decode handshake:
  - inst_valid = FIFO not empty; inst_data, inst_pc and opcode come combinationally from the FIFO head.
  - Pop when inst_valid && inst_ready.
  - Push and pop in the same cycle when full: legal, count unchanged.
- PC arithmetic wraps modulo 2^ADDR_W; no overflow flag.
- Redirect (redirect_valid=1):
  - Flush the FIFO; inst_valid=0 the next cycle. A same-cycle pop is ignored.
  - fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00}.
  - Redirect in WAIT: set discard=1. The next response is dropped, discard clears, and the FSM then requests the new PC.
  - Redirect in REQ, request not yet accepted: the address switches to the new PC the next cycle.
  - Redirect in REQ with a same-cycle handshake: treat the request as outstanding and set discard.
  - Redirect coincident with a response in WAIT: drop that response, discard stays 0, state goes to REQ.
- Requests are never cancelled once accepted; a response is always consumed.
- Reset mid-transaction: all state clears immediately. Memory responses arriving after reset release with no outstanding request are ignored.

Optional Feature:
Macro IFETCH_PERF_EN.
- Defined:
  - Adds output perf_fetched (32-bit): count of instructions popped to decode.
  - Adds output perf_redirects (32-bit): count of redirect pulses.
  - Both reset to 0 and wrap at 2^32.
  - Adds output perf_discarded (16-bit): count of dropped stale responses, saturating at 16'hFFFF.
- Not defined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Reset, memory returns 32'h00000033, 32'h00000013, 32'h00000003, 32'h00000023, 32'h00000063 at PCs 0,4,8,C,10 with 1-cycle latency, inst_ready=1 -> decode receives these five words in order with matching inst_pc; opcode = 33,13,03,23,63.
2. inst_ready=0 for 10 cycles -> at most FIFO_DEPTH words are buffered, then imem_req_valid stays 0; after inst_ready rises, all words drain in order with no loss and no duplicates.
3. Redirect to 0x100 while a response for PC 0x8 is in flight (latency 3) -> the 0x8 word is never presented; the next inst_pc is 0x100.
4. redirect_pc=0x203 -> fetch address 0x200.
5. imem_req_ready held low 5 cycles -> imem_req_addr and imem_req_valid stay stable throughout.
6. Assert rst asynchronously mid-WAIT -> outputs reach reset values without a clock edge; after release, the first request address is RESET_PC.

Source files
------------

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch front end: PC, single-outstanding imem requests, decode FIFO
// Optional IFETCH_PERF_EN adds fetched/redirect/discarded performance counters.
module ifetch_unit #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [6:0]        opcode,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_redirects,
  output logic [15:0]       perf_discarded
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              discard_q, discard_d;
  logic [31:0]       data_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] pc_q   [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] redir_pc;
  logic              push, pop, rsp_drop;

  assign redir_pc = {redirect_pc[ADDR_W-1:2], 2'b00};

  assign inst_valid = (count_q != '0);
  assign pop        = inst_valid && inst_ready && !redirect_valid;
  assign push       = (state_q == ST_WAIT) && imem_rsp_valid && !discard_q && !redirect_valid;
  assign rsp_drop   = (state_q == ST_WAIT) && imem_rsp_valid && (discard_q || redirect_valid);

  assign inst_data = inst_valid ? data_q[rd_ptr_q] : '0;
  assign inst_pc   = inst_valid ? pc_q[rd_ptr_q] : '0;
  assign opcode    = inst_data[6:0];

  assign imem_req_valid = (state_q == ST_REQ);
  assign imem_req_addr  = fetch_pc_q;

  // count_d already includes this cycle's push/pop, so a slot seen free here
  // stays free until the reserved response lands.
  always_comb begin
    count_d = redirect_valid ? '0 : (count_q + CNT_W'(push) - CNT_W'(pop));
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q;
    case (state_q)
      ST_IDLE: begin
        if (count_d < DEPTH_C) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (imem_req_ready) begin
          fetch_pc_d = fetch_pc_q + ADDR_W'(4);
          state_d    = ST_WAIT;
          if (redirect_valid) discard_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          discard_d = 1'b0;
          state_d   = (count_d < DEPTH_C) ? ST_REQ : ST_IDLE;
        end else if (redirect_valid) begin
          discard_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (redirect_valid) fetch_pc_d = redir_pc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      discard_q  <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      if (redirect_valid) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) begin
          data_q[wr_ptr_q] <= imem_rsp_data;
          pc_q[wr_ptr_q]   <= fetch_pc_q - ADDR_W'(4);
          wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched   <= '0;
      perf_redirects <= '0;
      perf_discarded <= '0;
    end else begin
      if (pop) perf_fetched <= perf_fetched + 32'd1;
      if (redirect_valid) perf_redirects <= perf_redirects + 32'd1;
      if (rsp_drop && (perf_discarded != 16'hFFFF)) perf_discarded <= perf_discarded + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - directed self-checking bench for ifetch_unit
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_data, inst_pc;
  logic [6:0]  opcode;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int n_checks = 0;
  int n_fail   = 0;

  // memory model state
  int          lat = 1;
  logic        hs_n;
  logic [31:0] a_n;
  logic        pend = 1'b0;
  int          cnt;
  logic [31:0] paddr;
  int          hs_count = 0;

  logic [31:0] gq_pc[$];
  logic [31:0] gq_data[$];
  logic [6:0]  gq_op[$];

  always #5 clk = ~clk;

  ifetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .opcode         (opcode),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   mem_word = 32'h0000_0033;
      32'h4:   mem_word = 32'h0000_0013;
      32'h8:   mem_word = 32'h0000_0003;
      32'hC:   mem_word = 32'h0000_0023;
      32'h10:  mem_word = 32'h0000_0063;
      default: mem_word = {a[24:0], 7'h37};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      hs_n = imem_req_valid && imem_req_ready;
      a_n  = imem_req_addr;
    end
  end

  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (hs_n) begin
          pend  = 1'b1;
          cnt   = lat;
          paddr = a_n;
          hs_count++;
        end
        if (pend) begin
          if (cnt == 1) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(paddr);
            pend = 1'b0;
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && inst_valid && inst_ready && !redirect_valid) begin
      gq_pc.push_back(inst_pc);
      gq_data.push_back(inst_data);
      gq_op.push_back(opcode);
    end
  end

  initial begin
    logic [31:0] exp_op [5];
    int   n, idx, hs0;
    logic bad;
    exp_op[0] = 32'h33; exp_op[1] = 32'h13; exp_op[2] = 32'h03;
    exp_op[3] = 32'h23; exp_op[4] = 32'h63;

    rst = 1'b1;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    tick(); tick();
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_req_addr", imem_req_addr, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst_data", inst_data, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_opcode", opcode, 0);

    // 1: in-order stream, latency 1
    rst = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    chk("t1_count_ge5", gq_pc.size() >= 5, 1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t1_pc%0d", i), (gq_pc.size() > i) ? gq_pc[i] : 'x, 4 * i);
      chk($sformatf("t1_data%0d", i), (gq_data.size() > i) ? gq_data[i] : 'x, exp_op[i]);
      chk($sformatf("t1_op%0d", i), (gq_op.size() > i) ? gq_op[i] : 'x, exp_op[i]);
    end

    // 2: decode stall, bounded buffering, then lossless drain
    inst_ready = 1'b0;
    hs0 = hs_count;
    for (int i = 0; i < 10; i++) tick();
    chk("t2_req_idle", imem_req_valid, 0);
    chk("t2_inst_valid", inst_valid, 1);
    chk("t2_reqs_le_depth", (hs_count - hs0) <= 2, 1);
    inst_ready = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    bad = 1'b0;
    for (int i = 0; i < gq_pc.size(); i++)
      if (gq_pc[i] !== 32'(4 * i) || gq_data[i] !== mem_word(32'(4 * i))) bad = 1'b1;
    chk("t2_seq_order", bad, 0);
    chk("t2_seq_len", gq_pc.size() >= 20, 1);

    // 3: redirect while PC 0x8 response is in flight
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    gq_pc.delete(); gq_data.delete(); gq_op.delete();
    lat = 3;
    n = 0;
    while (!(pend && paddr == 32'h8) && n < 50) begin tick(); n++; end
    chk("t3_wait_pc8", n < 50, 1);
    idx = gq_pc.size();
    pulse_redirect(32'h100);
    chk("t3_flush", inst_valid, 0);
    for (int i = 0; i < 30; i++) tick();
    bad = 1'b0;
    for (int i = 0; i < gq_pc.size(); i++) if (gq_pc[i] == 32'h8) bad = 1'b1;
    chk("t3_no_stale", bad, 0);
    chk("t3_next_pc", (gq_pc.size() > idx) ? gq_pc[idx] : 'x, 32'h100);
    chk("t3_next_data", (gq_data.size() > idx) ? gq_data[idx] : 'x, mem_word(32'h100));

    // 4: unaligned redirect target is word-aligned
    idx = gq_pc.size();
    pulse_redirect(32'h203);
    n = 0;
    while (!imem_req_valid && n < 20) begin tick(); n++; end
    chk("t4_wait_req", n < 20, 1);
    chk("t4_addr", imem_req_addr, 32'h200);
    for (int i = 0; i < 20; i++) tick();
    chk("t4_next_pc", (gq_pc.size() > idx) ? gq_pc[idx] : 'x, 32'h200);

    // 5: request held stable while memory stalls, then retargeted
    imem_req_ready = 1'b0;
    pulse_redirect(32'h300);
    n = 0;
    while (!imem_req_valid && n < 20) begin tick(); n++; end
    chk("t5_wait_req", n < 20, 1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t5_stable%0d", i), {imem_req_valid, imem_req_addr}, {1'b1, 32'h300});
      tick();
    end
    idx = gq_pc.size();
    pulse_redirect(32'h400);
    chk("t5_retarget", {imem_req_valid, imem_req_addr}, {1'b1, 32'h400});
    imem_req_ready = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("t5_next_pc", (gq_pc.size() > idx) ? gq_pc[idx] : 'x, 32'h400);

    // 6: asynchronous reset while waiting for a response
    inst_ready = 1'b0;
    n = 0;
    while (!(pend && inst_valid) && n < 50) begin tick(); n++; end
    chk("t6_wait_wait", n < 50, 1);
    #1 rst = 1'b1;
    #1;
    chk("t6_req_valid", imem_req_valid, 0);
    chk("t6_req_addr", imem_req_addr, 0);
    chk("t6_inst_valid", inst_valid, 0);
    chk("t6_inst_data", inst_data, 0);
    chk("t6_inst_pc", inst_pc, 0);
    chk("t6_opcode", opcode, 0);
    tick(); tick();
    rst = 1'b0;
    inst_ready = 1'b1;
    idx = gq_pc.size();
    n = 0;
    while (!imem_req_valid && n < 20) begin tick(); n++; end
    chk("t6_wait_req", n < 20, 1);
    chk("t6_first_addr", imem_req_addr, 0);
    for (int i = 0; i < 20; i++) tick();
    chk("t6_first_pc", (gq_pc.size() > idx) ? gq_pc[idx] : 'x, 0);
    chk("t6_first_data", (gq_data.size() > idx) ? gq_data[idx] : 'x, 32'h33);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
